// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-addressed RAM: alignment, lane select, extension, sub-word RMW.
// One request in flight; fault 1 cycle, load/word store 2, sub-word store 3; req_ready high only in IDLE.
module load_store_unit #(
  parameter int N = 32,
  parameter int M = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [1:0]   req_size,
  input  logic         req_unsigned,
  input  logic [N-1:0] req_addr,
  input  logic [N-1:0] req_wdata,
  output logic         resp_valid,
  output logic [N-1:0] resp_rdata,
  output logic         resp_misaligned,
  output logic         resp_oob,
  output logic [N-1:0] mem_address,
  output logic [N-1:0] mem_data_input,
  output logic         mem_memread,
  output logic         mem_memwrite,
  input  logic [N-1:0] mem_data
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    STORE     = 3'd2,
    RMW_READ  = 3'd3,
    RMW_WRITE = 3'd4,
    RESP      = 3'd5
  } state_t;

  state_t       state_q, state_d;
  logic         write_q, write_d;
  logic [1:0]   size_q, size_d;
  logic         unsigned_q, unsigned_d;
  logic [N-1:0] addr_q, addr_d;
  logic [N-1:0] wdata_q, wdata_d;
  logic [N-1:0] merge_q, merge_d;
  logic [N-1:0] rdata_q, rdata_d;
  logic         mis_q, mis_d;
  logic         oob_q, oob_d;

  logic         mis_in;
  logic         oob_in;
  logic [4:0]   byte_sh;
  logic [7:0]   lane_b;
  logic [15:0]  lane_h;
  logic [N-1:0] load_ext;
  logic [N-1:0] merged;

  // Fault classification is done on the live request so a bad access never reaches memory.
  always_comb begin
    mis_in = (req_size == 2'b11) ||
             (req_size == 2'b01 && req_addr[0]) ||
             (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    oob_in = ({2'b00, req_addr[N-1:2]} >= N'(M));
  end

  always_comb begin
    byte_sh = {addr_q[1:0], 3'b000};
    lane_b  = mem_data[byte_sh +: 8];
    lane_h  = addr_q[1] ? mem_data[N-1:N-16] : mem_data[15:0];
    case (size_q)
      2'b00:   load_ext = unsigned_q ? {{(N-8){1'b0}}, lane_b} : {{(N-8){lane_b[7]}}, lane_b};
      2'b01:   load_ext = unsigned_q ? {{(N-16){1'b0}}, lane_h} : {{(N-16){lane_h[15]}}, lane_h};
      default: load_ext = mem_data;
    endcase
    merged = merge_q;
    if (size_q == 2'b00) begin
      merged[byte_sh +: 8] = wdata_q[7:0];
    end else begin
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      write_q    <= 1'b0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      merge_q    <= '0;
      rdata_q    <= '0;
      mis_q      <= 1'b0;
      oob_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      merge_q    <= merge_d;
      rdata_q    <= rdata_d;
      mis_q      <= mis_d;
      oob_q      <= oob_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    merge_d    = merge_q;
    rdata_d    = rdata_q;
    mis_d      = mis_q;
    oob_d      = oob_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          write_d    = req_write;
          size_d     = req_size;
          unsigned_d = req_unsigned;
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          if (mis_in || oob_in) begin
            state_d = RESP;
            rdata_d = '0;
            mis_d   = mis_in;
            oob_d   = oob_in;
          end else if (!req_write) begin
            state_d = LOAD;
          end else if (req_size == 2'b10) begin
            state_d = STORE;
          end else begin
            state_d = RMW_READ;
          end
        end
      end
      LOAD: begin
        rdata_d = load_ext;
        mis_d   = 1'b0;
        oob_d   = 1'b0;
        state_d = RESP;
      end
      STORE, RMW_WRITE: begin
        rdata_d = '0;
        mis_d   = 1'b0;
        oob_d   = 1'b0;
        state_d = RESP;
      end
      RMW_READ: begin
        merge_d = mem_data;
        state_d = RMW_WRITE;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Enables are gated by rst so a write in flight is suppressed in the reset cycle itself.
  always_comb begin
    req_ready      = (state_q == IDLE) && !rst;
    mem_memread    = ((state_q == LOAD) || (state_q == RMW_READ)) && !rst;
    mem_memwrite   = ((state_q == STORE) || (state_q == RMW_WRITE)) && !rst;
    mem_data_input = (state_q == RMW_WRITE) ? merged : wdata_q;
    resp_valid     = (state_q == RESP) && !rst;
  end

  assign mem_address     = {2'b00, addr_q[N-1:2]};
  assign resp_rdata      = rdata_q;
  assign resp_misaligned = mis_q;
  assign resp_oob        = oob_q;

  logic unused_write;
  assign unused_write = write_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: behavioural RAM, byte-level reference model, directed and random requests.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_misaligned, resp_oob;
  logic [31:0] resp_rdata;
  logic [31:0] mem_address, mem_data_input, mem_data;
  logic        mem_memread, mem_memwrite;

  load_store_unit #(.N(32), .M(256)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_misaligned(resp_misaligned), .resp_oob(resp_oob),
    .mem_address(mem_address), .mem_data_input(mem_data_input),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  logic [31:0] ram [0:255];
  logic [31:0] ref_mem [0:255];
  logic        clr;

  assign mem_data = (mem_address < 32'd256) ? ram[mem_address[7:0]] : 32'h0;

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
    end else if (mem_memwrite && mem_address < 32'd256) begin
      ram[mem_address[7:0]] <= mem_data_input;
    end
  end

  int rd_cnt = 0, wr_cnt = 0, resp_cnt = 0;
  always @(negedge clk) begin
    if (mem_memread)  rd_cnt++;
    if (mem_memwrite) wr_cnt++;
    if (resp_valid)   resp_cnt++;
  end

  int vec = 0, err = 0;

  int          o_lat, o_nrd, o_nwr, e_lat, e_nrd, e_nwr;
  logic [31:0] o_rd, e_rd;
  logic        o_m, o_o, e_m, e_o;

  // Reference: byte-addressed memory semantics expressed with masks and shifts.
  task automatic model(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] word, v, mask;
    int          idx, sh;
    e_m = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    e_o = (a >> 2) >= 32'd256;
    e_rd = 32'h0;
    idx = int'(a >> 2);
    if (e_m || e_o) begin
      e_lat = 1; e_nrd = 0; e_nwr = 0;
    end else if (!w) begin
      word = ref_mem[idx];
      e_lat = 2; e_nrd = 1; e_nwr = 0;
      if (sz == 2'd0) begin
        v = (word >> (8 * a[1:0])) & 32'hFF;
        e_rd = (u || v < 32'h80) ? v : v + 32'hFFFF_FF00;
      end else if (sz == 2'd1) begin
        v = (word >> (16 * a[1])) & 32'hFFFF;
        e_rd = (u || v < 32'h8000) ? v : v + 32'hFFFF_0000;
      end else begin
        e_rd = word;
      end
    end else if (sz == 2'd2) begin
      ref_mem[idx] = wd;
      e_lat = 2; e_nrd = 0; e_nwr = 1;
    end else begin
      sh = (sz == 2'd0) ? 8 * a[1:0] : 16 * a[1];
      mask = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
      ref_mem[idx] = (ref_mem[idx] & ~mask) | ((wd << sh) & mask);
      e_lat = 3; e_nrd = 1; e_nwr = 1;
    end
  endtask

  task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd);
    int waitc = 0;
    int r0, w0;
    @(negedge clk);
    while (!req_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    r0 = rd_cnt; w0 = wr_cnt;
    #1 req_valid = 1'b0;
    o_lat = 99;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        o_lat = i;
        break;
      end
    end
    o_rd = resp_rdata; o_m = resp_misaligned; o_o = resp_oob;
    o_nrd = rd_cnt - r0; o_nwr = wr_cnt - w0;
  endtask

  task automatic run(input logic w, input logic [1:0] sz, input logic u,
                     input logic [31:0] a, input logic [31:0] wd);
    model(w, sz, u, a, wd);
    do_req(w, sz, u, a, wd);
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    vec++;
    if ({req_ready, resp_valid, resp_misaligned, resp_oob, mem_memread, mem_memwrite} !== 6'b0 ||
        resp_rdata !== 32'h0 || mem_address !== 32'h0 || mem_data_input !== 32'h0) begin
      err++;
      $display("FAIL reset_outputs: rdy=%b vld=%b mis=%b oob=%b rd=%b wr=%b rdata=%h addr=%h din=%h, want all 0",
               req_ready, resp_valid, resp_misaligned, resp_oob, mem_memread, mem_memwrite,
               resp_rdata, mem_address, mem_data_input);
    end
    @(posedge clk); #1 rst = 1'b0; clr = 1'b0;
    @(negedge clk);
    vec++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_misaligned !== 1'b0 || resp_oob !== 1'b0) begin
      err++;
      $display("FAIL reset_release: rdy=%b vld=%b mis=%b oob=%b, want 1 0 0 0",
               req_ready, resp_valid, resp_misaligned, resp_oob);
    end
  endtask

  task automatic test_word_then_loads();
    run(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
    vec++;
    if (o_lat !== 2 || o_nwr !== 1 || o_nrd !== 0 || ram[4] !== 32'hDEADBEEF) begin
      err++;
      $display("FAIL sw_0x10: lat=%0d wr=%0d rd=%0d word4=%h, want 2 1 0 deadbeef", o_lat, o_nwr, o_nrd, ram[4]);
    end
    run(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    vec++;
    if (o_rd !== 32'hDEADBEEF || o_lat !== 2 || o_nrd !== 1) begin
      err++;
      $display("FAIL lw_0x10: rdata=%h lat=%0d rd=%0d, want deadbeef 2 1", o_rd, o_lat, o_nrd);
    end
    run(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
    vec++;
    if (o_rd !== 32'hFFFFFFDE) begin
      err++;
      $display("FAIL lb_0x13: rdata=%h, want ffffffde", o_rd);
    end
    run(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
    vec++;
    if (o_rd !== 32'h000000DE) begin
      err++;
      $display("FAIL lbu_0x13: rdata=%h, want 000000de", o_rd);
    end
  endtask

  task automatic test_rmw();
    run(1'b1, 2'd0, 1'b0, 32'h11, 32'h55);
    vec++;
    if (o_lat !== 3 || o_nrd !== 1 || o_nwr !== 1 || ram[4] !== 32'hDEAD55EF || o_rd !== 32'h0) begin
      err++;
      $display("FAIL sb_0x11: lat=%0d rd=%0d wr=%0d word4=%h rdata=%h, want 3 1 1 dead55ef 0",
               o_lat, o_nrd, o_nwr, ram[4], o_rd);
    end
    run(1'b1, 2'd1, 1'b0, 32'h12, 32'h1234);
    vec++;
    if (o_lat !== 3 || ram[4] !== 32'h123455EF) begin
      err++;
      $display("FAIL sh_0x12: lat=%0d word4=%h, want 3 123455ef", o_lat, ram[4]);
    end
    run(1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
    vec++;
    if (o_rd !== 32'h00001234) begin
      err++;
      $display("FAIL lh_0x12: rdata=%h, want 00001234", o_rd);
    end
    run(1'b0, 2'd1, 1'b0, 32'h10, 32'h0);
    vec++;
    if (o_rd !== 32'h000055EF) begin
      err++;
      $display("FAIL lh_0x10: rdata=%h, want 000055ef", o_rd);
    end
    @(negedge clk); @(negedge clk);
    vec++;
    if (resp_rdata !== 32'h000055EF || resp_valid !== 1'b0) begin
      err++;
      $display("FAIL resp_hold: rdata=%h vld=%b, want 000055ef 0", resp_rdata, resp_valid);
    end
  endtask

  task automatic test_faults();
    run(1'b0, 2'd2, 1'b0, 32'h06, 32'h0);
    vec++;
    if (o_m !== 1'b1 || o_o !== 1'b0 || o_rd !== 32'h0 || o_lat !== 1 || o_nrd !== 0) begin
      err++;
      $display("FAIL lw_0x06: mis=%b oob=%b rdata=%h lat=%0d rd=%0d, want 1 0 0 1 0", o_m, o_o, o_rd, o_lat, o_nrd);
    end
    run(1'b1, 2'd1, 1'b0, 32'h21, 32'hFFFF);
    vec++;
    if (o_m !== 1'b1 || o_lat !== 1 || o_nrd !== 0 || o_nwr !== 0 || ram[8] !== ref_mem[8]) begin
      err++;
      $display("FAIL sh_0x21: mis=%b lat=%0d rd=%0d wr=%0d, want 1 1 0 0", o_m, o_lat, o_nrd, o_nwr);
    end
    run(1'b0, 2'd3, 1'b0, 32'h08, 32'h0);
    vec++;
    if (o_m !== 1'b1 || o_lat !== 1) begin
      err++;
      $display("FAIL size_11: mis=%b lat=%0d, want 1 1", o_m, o_lat);
    end
    run(1'b0, 2'd2, 1'b0, 32'h400, 32'h0);
    vec++;
    if (o_o !== 1'b1 || o_m !== 1'b0 || o_nrd !== 0 || o_nwr !== 0 || o_lat !== 1) begin
      err++;
      $display("FAIL lw_0x400: oob=%b mis=%b rd=%0d wr=%0d lat=%0d, want 1 0 0 0 1", o_o, o_m, o_nrd, o_nwr, o_lat);
    end
    run(1'b1, 2'd1, 1'b0, 32'h403, 32'h0);
    vec++;
    if (o_o !== 1'b1 || o_m !== 1'b1 || o_nwr !== 0) begin
      err++;
      $display("FAIL sh_0x403: oob=%b mis=%b wr=%0d, want 1 1 0", o_o, o_m, o_nwr);
    end
  endtask

  task automatic test_back_to_back();
    logic        bw [4];
    logic [31:0] ba [4];
    logic [31:0] bd [4];
    logic [31:0] got [$];
    logic [31:0] v1, v2;
    int          idx = 0, cyc = 0, base;
    bit          inflight = 0, rdy;
    v1 = $urandom; v2 = $urandom;
    bw = '{1'b1, 1'b0, 1'b1, 1'b0};
    ba = '{32'h50, 32'h50, 32'h54, 32'h54};
    bd = '{v1, 32'h0, v2, 32'h0};
    for (int i = 0; i < 4; i++) model(bw[i], 2'd2, 1'b0, ba[i], bd[i]);
    @(negedge clk);
    base = resp_cnt;
    req_write = bw[0]; req_size = 2'd2; req_unsigned = 1'b0; req_addr = ba[0]; req_wdata = bd[0];
    req_valid = 1'b1;
    while ((idx < 4 || got.size() < 4) && cyc < 60) begin
      if (inflight) begin
        vec++;
        if (req_ready !== 1'b0) begin
          err++;
          $display("FAIL b2b_ready_busy: req_ready=%b at cycle %0d, want 0", req_ready, cyc);
        end
      end
      if (resp_valid) begin
        got.push_back(resp_rdata);
        inflight = 0;
      end
      rdy = req_ready && req_valid;
      @(posedge clk); #1;
      if (rdy) begin
        inflight = 1;
        idx++;
        if (idx < 4) begin
          req_write = bw[idx]; req_addr = ba[idx]; req_wdata = bd[idx];
        end else begin
          req_valid = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    vec++;
    if (resp_cnt - base !== 4 || got.size() !== 4) begin
      err++;
      $display("FAIL b2b_count: pulses=%0d recorded=%0d, want 4 4", resp_cnt - base, got.size());
    end else begin
      vec++;
      if (got[0] !== 32'h0 || got[1] !== v1 || got[2] !== 32'h0 || got[3] !== v2) begin
        err++;
        $display("FAIL b2b_order: got %h %h %h %h, want 0 %h 0 %h", got[0], got[1], got[2], got[3], v1, v2);
      end
    end
  endtask

  task automatic test_reset_mid_rmw();
    int base;
    run(1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344);
    @(negedge clk);
    base = resp_cnt;
    req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0; req_addr = 32'h20; req_wdata = 32'hAA;
    req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    vec++;
    if (mem_memread !== 1'b1) begin
      err++;
      $display("FAIL mid_rmw_read: memread=%b, want 1", mem_memread);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    vec++;
    if (mem_memwrite !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b0) begin
      err++;
      $display("FAIL mid_rmw_rst: memwrite=%b vld=%b rdy=%b, want 0 0 0", mem_memwrite, resp_valid, req_ready);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    vec++;
    if (req_ready !== 1'b1 || ram[8] !== 32'h11223344) begin
      err++;
      $display("FAIL mid_rmw_after: rdy=%b word8=%h, want 1 11223344", req_ready, ram[8]);
    end
    repeat (3) @(negedge clk);
    vec++;
    if (resp_cnt !== base) begin
      err++;
      $display("FAIL mid_rmw_noresp: pulses=%0d, want 0", resp_cnt - base);
    end
  endtask

  task automatic test_random();
    logic        w, u;
    logic [1:0]  sz;
    logic [31:0] a;
    for (int n = 0; n < 150; n++) begin
      w  = 1'($urandom_range(0, 1));
      u  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a  = $urandom_range(0, 1100);
      if ($urandom_range(0, 3) != 0) a = a & ((sz == 2'd2) ? ~32'h3 : (sz == 2'd1) ? ~32'h1 : ~32'h0);
      run(w, sz, u, a, $urandom);
      vec++;
      if (o_lat !== e_lat) begin
        err++; $display("FAIL rnd_lat[%0d]: got %0d, want %0d (addr=%h sz=%0d w=%b)", n, o_lat, e_lat, a, sz, w);
      end
      vec++;
      if (o_rd !== e_rd) begin
        err++; $display("FAIL rnd_rdata[%0d]: got %h, want %h (addr=%h sz=%0d u=%b)", n, o_rd, e_rd, a, sz, u);
      end
      vec++;
      if (o_m !== e_m || o_o !== e_o) begin
        err++; $display("FAIL rnd_flags[%0d]: mis/oob %b%b, want %b%b (addr=%h sz=%0d)", n, o_m, o_o, e_m, e_o, a, sz);
      end
      vec++;
      if (o_nrd !== e_nrd || o_nwr !== e_nwr) begin
        err++; $display("FAIL rnd_memops[%0d]: rd/wr %0d/%0d, want %0d/%0d", n, o_nrd, o_nwr, e_nrd, e_nwr);
      end
    end
  endtask

  task automatic test_memory_image();
    int bad = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== ref_mem[i]) bad++;
    vec++;
    if (bad != 0) begin
      err++;
      $display("FAIL mem_image: %0d words differ from reference, want 0", bad);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
    test_reset();
    test_word_then_loads();
    test_rmw();
    test_faults();
    test_back_to_back();
    test_reset_mid_rmw();
    test_random();
    test_memory_image();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage that sits directly upstream of the word-addressed data memory (the synchronous-write, combinational-read RAM).
- Takes byte-addressed load/store requests from the execute stage and performs alignment, lane selection and sign/zero extension.
- Performs read-modify-write for sub-word stores, and checks alignment and range before any memory access.
- Returns one response per request to the writeback/pipeline controller through a valid/ready request channel and a one-cycle response pulse.

Parameters:
- N, 32, data and address width; only 32 is supported.
- M, 256, data memory depth in words; word index >= M is out of range.

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  synchronous active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept; 1 only in IDLE with rst low.
- req_write  input  1  1=store, 0=load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  input  1  loads: 1=zero-extend, 0=sign-extend; ignored for stores and word loads.
- req_addr  input  N  byte address.
- req_wdata  input  N  store data; low bits are used for sub-word stores.
- resp_valid  output  1  one-cycle pulse: request completed.
- resp_rdata  output  N  extended load data; 0 for stores and faults.
- resp_misaligned  output  1  alignment fault or reserved size.
- resp_oob  output  1  word index >= M.
- mem_address  output  N  word index = req_addr >> 2, zero-filled upper bits.
- mem_data_input  output  N  write data to memory.
- mem_memread  output  1  memory read enable.
- mem_memwrite  output  1  memory write enable.
- mem_data  input  N  combinational read data from memory.

Behaviour:
- **Accept and capture.** A request is accepted on a posedge where req_valid&&req_ready. At that edge, write, size, unsigned, addr and wdata are captured. Request inputs are don't-care afterwards.
- **States:** IDLE, LOAD, STORE, RMW_READ, RMW_WRITE, RESP.
- **Fault check at accept.**
  - Misaligned: size=11, or half with addr[0]=1, or word with addr[1:0]!=0.
  - OOB: (addr>>2) >= M.
  - If both apply, both flags are set.
  - Any fault goes directly to RESP with no memory activity.
- **Transitions from IDLE on accept:**
  - Fault → RESP.
  - Load → LOAD.
  - Word store → STORE.
  - Byte or half store → RMW_READ.
- **LOAD:** mem_memread=1. At the edge, capture mem_data lane(s), extend, store in the result register, then go to RESP.
- **STORE:** mem_memwrite=1, mem_data_input=wdata; the memory writes at the edge. Go to RESP.
- **RMW_READ:** mem_memread=1. At the edge, capture the full word into the merge register, then go to RMW_WRITE.
- **RMW_WRITE:** mem_memwrite=1. mem_data_input = merge register with the target lane(s) replaced. Go to RESP.
- **RESP:** resp_valid=1 for exactly one cycle, then IDLE. req_ready=0 during RESP.
- **Lane rules (little-endian).**
  - Byte lane k=addr[1:0] occupies bits [8k+7:8k].
  - Half lane h=addr[1] occupies bits [16h+15:16h].
  - Sub-word stores take wdata[7:0] or wdata[15:0].
- **Latency from accept edge to the resp_valid cycle:**
  - Fault: 1 cycle.
  - Load or word store: 2 cycles.
  - Sub-word store: 3 cycles.
  - Throughput: one request in flight.
- **Memory outputs outside access states:** mem_memread=0, mem_memwrite=0; mem_address and mem_data_input hold the captured values, not X.
- **Response hold:** resp_rdata, resp_misaligned and resp_oob hold until the next RESP overwrites them.
- **Reset.** When rst=1:
  - state→IDLE; resp_valid, resp_rdata and both flags→0; merge register→0.
  - req_ready=0, mem_memread=0 and mem_memwrite=0 during the rst cycle (enables gated combinationally by !rst).
- **Reset mid-operation:** the in-flight request is dropped with no response. rst during RMW_WRITE or STORE suppresses the write, so memory is unchanged.
- **req_valid held through RESP:** not accepted until the following IDLE cycle.

Test Plan:
- **Word store, then loads.** Reset; SW addr=0x10 wdata=0xDEADBEEF → memwrite pulse at word 4, resp_valid 2 cycles after accept. Then LW 0x10 → rdata=0xDEADBEEF. LB 0x13 signed → 0xFFFFFFDE. LBU 0x13 → 0x000000DE.
- **Sub-word RMW stores.**
  - With word 4=0xDEADBEEF, SB addr=0x11 wdata=0x55 → RMW_READ then RMW_WRITE, word 4=0xDEAD55EF, resp 3 cycles after accept.
  - SH 0x12 wdata=0x1234 → word 4=0x123455EF.
  - LH 0x12 → 0x00001234; LH 0x10 → 0x000055EF.
- **Faults.** LW 0x06 → resp_misaligned=1, rdata=0, no memread, resp 1 cycle after accept. SH 0x21 likewise. size=11 → misaligned. LW 0x400 with M=256 → resp_oob=1, no memory access.
- **Back-to-back.** req_valid held high for 4 requests → req_ready low from accept through RESP; exactly 4 resp pulses in order; no request lost or duplicated.
- **Reset mid-RMW.** SB 0x20 wdata=0xAA to word 8=0x11223344; assert rst in the RMW_WRITE cycle → no memwrite, word 8 still 0x11223344, no resp_valid, req_ready=1 the cycle after rst drops.
- **Reset values.** Hold rst 2 cycles → all outputs 0 and req_ready=0. After rst falls, req_ready=1 and resp flags remain 0.
